flat_vector_serdes_bridge: RTL

- Harness-side counterpart to the flattened-I/O wrappers.
- Receives a stimulus vector bit-serially and presents it in parallel as the wrapper's `in_flat`.
- Samples the wrapper's parallel `out_flat` response and returns it bit-serially.
- Lets a narrow serial fuzz/test channel drive any flattened DUT of width IN_W/OUT_W.

---
 rtl/flat_vector_serdes_bridge.sv | 136 +++++++++++++
 1 files changed

// File: rtl/flat_vector_serdes_bridge.sv
// Serial-to-parallel stimulus bridge for flattened-I/O wrappers: shifts in a vector,
// applies it for SETTLE_CYC cycles, then shifts the sampled response back out MSB first.
//   state     | meaning
//   IDLE      | post-reset, moves to SHIFT_IN on the next clock
//   SHIFT_IN  | accepting stimulus bits, vec_out holds previous vector
//   APPLY     | new vector driven, waiting SETTLE_CYC cycles
//   SHIFT_OUT | returning sampled response bits
module flat_vector_serdes_bridge #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bit,
  output logic [IN_W-1:0]  vec_out,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] resp_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_bit,
  output logic             m_last,
  output logic             busy
);

  localparam int MAX_A = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int MAX_W = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int CW    = $clog2(MAX_W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT_IN, APPLY, SHIFT_OUT} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  shift_q, shift_d, vec_q, vec_d, shift_next;
  logic [OUT_W-1:0] resp_q, resp_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d, settle_q, settle_d, idx_q, idx_d;
  logic             s_ready_q, s_ready_d, vec_valid_q, vec_valid_d;
  logic             m_valid_q, m_valid_d, m_bit_q, m_bit_d;
  logic             m_last_q, m_last_d, busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    vec_d      = vec_q;
    resp_d     = resp_q;
    bit_cnt_d  = bit_cnt_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    shift_next = (shift_q << 1) | IN_W'(s_bit);

    case (state_q)
      IDLE: state_d = SHIFT_IN;
      SHIFT_IN: begin
        if (s_valid && s_ready_q) begin
          shift_d = shift_next;
          if (bit_cnt_q == CW'(IN_W - 1)) begin
            vec_d     = shift_next;
            bit_cnt_d = '0;
            settle_d  = '0;
            state_d   = APPLY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      APPLY: begin
        if (settle_q == CW'(SETTLE_CYC - 1)) begin
          settle_d = '0;
          resp_d   = resp_in;
          idx_d    = CW'(OUT_W - 1);
          state_d  = SHIFT_OUT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SHIFT_OUT: begin
        // Response is kept MSB-aligned so the outgoing bit is always resp_q[OUT_W-1].
        if (m_valid_q && m_ready) begin
          resp_d = resp_q << 1;
          if (idx_q == '0) state_d = SHIFT_IN;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == SHIFT_IN);
    vec_valid_d = (state_d == APPLY);
    m_valid_d   = (state_d == SHIFT_OUT);
    busy_d      = (state_d == APPLY) || (state_d == SHIFT_OUT);
    m_bit_d     = m_valid_d && resp_d[OUT_W-1];
    m_last_d    = m_valid_d && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      vec_q       <= '0;
      resp_q      <= '0;
      bit_cnt_q   <= '0;
      settle_q    <= '0;
      idx_q       <= '0;
      s_ready_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_bit_q     <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      vec_q       <= vec_d;
      resp_q      <= resp_d;
      bit_cnt_q   <= bit_cnt_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      vec_valid_q <= vec_valid_d;
      m_valid_q   <= m_valid_d;
      m_bit_q     <= m_bit_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign vec_out   = vec_q;
  assign vec_valid = vec_valid_q;
  assign m_valid   = m_valid_q;
  assign m_bit     = m_bit_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;

endmodule
